key_onehot_debounce: RTL



---
 rtl/key_pkg.sv | 17 +
 rtl/debounce_line.sv | 43 ++++
 rtl/key_onehot_debounce.sv | 86 ++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key debounce / one-hot event front end.
package key_pkg;

    localparam int KEY_N            = 8;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic logic [KEY_N-1:0] lowest_bit(input logic [KEY_N-1:0] v);
        return v & (~v + KEY_N'(1));
    endfunction

endpackage

// File: rtl/debounce_line.sv
// One key line: two-flop synchroniser, stability counter, debounced state and
// a single-cycle pulse on the edge where the debounced state rises.
module debounce_line #(
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic             s1;
    logic             s2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             settled;

    // True on the edge that completes the run of differing samples.
    assign settled = (s2 != db) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise    = settled & s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (settled) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_onehot_debounce.sv
// Debounces eight raw key lines and issues press events one at a time as a
// one-hot word over valid/ready, lowest index first.
module key_onehot_debounce
    import key_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_N-1:0] key_raw,
    output logic [KEY_N-1:0] onehot_out,
    output logic             valid,
    input  logic             ready,
    output logic [KEY_N-1:0] pending,
    output logic             dropped
);

    logic [KEY_N-1:0] rise;
    logic [KEY_N-1:0] pick;
    logic [KEY_N-1:0] clr;
    logic [KEY_N-1:0] pending_nxt;
    logic [KEY_N-1:0] onehot_nxt;
    logic             valid_nxt;
    logic             dropped_nxt;
    state_t           state;
    state_t           state_nxt;

    for (genvar i = 0; i < KEY_N; i++) begin : g_line
        debounce_line #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .key (key_raw[i]),
            .rise(rise[i])
        );
    end

    assign pick = lowest_bit(pending);

    always_comb begin
        state_nxt   = state;
        onehot_nxt  = onehot_out;
        valid_nxt   = valid;
        clr         = '0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    onehot_nxt = pick;
                    valid_nxt  = 1'b1;
                    clr        = pick;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    onehot_nxt = '0;
                    valid_nxt  = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A fresh rise outranks the clear, so a re-press during issue survives.
        pending_nxt = (pending & ~clr) | rise;
        dropped_nxt = |(rise & pending & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            onehot_out <= '0;
            valid      <= 1'b0;
            pending    <= '0;
            dropped    <= 1'b0;
        end else begin
            state      <= state_nxt;
            onehot_out <= onehot_nxt;
            valid      <= valid_nxt;
            pending    <= pending_nxt;
            dropped    <= dropped_nxt;
        end
    end

endmodule
